// File: rtl/window_pkg.sv
// Shared constants, FSM state type and the Hamming coefficient table for the windowing stage.
// The table is computed at elaboration from the window formula, so it cannot drift from FRAME_LEN.
package window_pkg;

  localparam int FRAME_LEN = 256;
  localparam int SAMPLE_W  = 12;
  localparam int COEF_W    = 16;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int PROD_W    = SAMPLE_W + COEF_W;
  localparam int FRAC_W    = COEF_W - 1;

  localparam real PI = 3.14159265358979323846;

  typedef enum logic {IDLE, RUN} state_t;

  typedef logic [COEF_W-1:0] coef_table_t [0:FRAME_LEN-1];

  // Q1.15 cannot hold 1.0, so the two centre taps clamp to 32767.
  function automatic coef_table_t gen_hamming_coef();
    coef_table_t tbl;
    real         w;
    int          v;
    for (int n = 0; n < FRAME_LEN; n++) begin
      w = 32768.0 * (0.54 - 0.46 * $cos(2.0 * PI * real'(n) / real'(FRAME_LEN - 1)));
      v = $rtoi(w + 0.5);
      if (v > 32767) v = 32767;
      tbl[n] = COEF_W'(v);
    end
    return tbl;
  endfunction

  localparam coef_table_t HAMMING_COEF = gen_hamming_coef();

endpackage

// File: rtl/window_coef_rom.sv
// Registered coefficient ROM: one-cycle read latency, indexed by sample position.
module window_coef_rom
  import window_pkg::*;
(
  input  logic              clk,
  input  logic [IDX_W-1:0]  addr,
  output logic [COEF_W-1:0] coef
);

  always_ff @(posedge clk) begin
    coef <= HAMMING_COEF[addr];
  end

endmodule

// File: rtl/hamming_window.sv
// Streams a Hamming-windowed frame, one sample per cycle, reading the framing bus in place.
// Build option: define HAMMING_WINDOW_ROUND_EN for round-half-up instead of truncation.
//
// state | meaning
// IDLE  | waiting for frame_ready; read address parked at 0
// RUN   | reading element idx each cycle until 255 has been read
module hamming_window
  import window_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] frame_in [0:FRAME_LEN-1],
  input  logic                frame_ready,
  output logic [SAMPLE_W-1:0] win_sample,
  output logic [7:0]          win_index,
  output logic                win_valid,
  output logic                win_last,
  output logic                busy,
  output logic                overrun
);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     rd_addr;
  logic                 capture;

  logic [SAMPLE_W-1:0]  s1_sample;
  logic [COEF_W-1:0]    s1_coef;
  logic [IDX_W-1:0]     s1_idx;
  logic                 s1_valid;

  logic [PROD_W-1:0]    prod;
  logic [PROD_W-1:0]    prod_sh;
  logic [SAMPLE_W-1:0]  result;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (frame_ready) begin
          state_d = RUN;
          idx_d   = IDX_W'(1);
        end
      end
      RUN: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    rd_addr = '0;
    capture = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: capture = frame_ready;
      RUN: begin
        rd_addr = idx_q;
        capture = 1'b1;
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

  // A strobe arriving mid-frame is dropped; the running frame is untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (state_q == RUN && frame_ready) begin
      overrun <= 1'b1;
    end
  end

  window_coef_rom u_coef_rom (
    .clk  (clk),
    .addr (rd_addr),
    .coef (s1_coef)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sample <= '0;
      s1_idx    <= '0;
    end else begin
      s1_valid <= capture;
      if (capture) begin
        s1_sample <= frame_in[rd_addr];
        s1_idx    <= rd_addr;
      end
    end
  end

  assign prod = PROD_W'(s1_sample) * PROD_W'(s1_coef);

`ifdef HAMMING_WINDOW_ROUND_EN
  localparam logic [PROD_W-1:0] ROUND_HALF = PROD_W'(1) << (FRAC_W - 1);
  assign prod_sh = (prod + ROUND_HALF) >> FRAC_W;
`else
  assign prod_sh = prod >> FRAC_W;
`endif

  // Coefficients stay below 1.0, so the scaled product always fits SAMPLE_W.
  assign result = SAMPLE_W'(prod_sh);

  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid  <= 1'b0;
      win_last   <= 1'b0;
      win_sample <= '0;
      win_index  <= '0;
    end else begin
      win_valid <= s1_valid;
      win_last  <= s1_valid && (s1_idx == IDX_W'(FRAME_LEN - 1));
      if (s1_valid) begin
        win_sample <= result;
        win_index  <= s1_idx;
      end
    end
  end

endmodule

// File: tb/tb_hamming_window.sv
// Self-checking bench for hamming_window: per-cycle reference model plus spot-value table.
module tb_hamming_window;

  localparam int FL   = 256;
  localparam int SW   = 12;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] frame_in [0:FL-1];
  logic          frame_ready;
  logic [SW-1:0] win_sample;
  logic [7:0]    win_index;
  logic          win_valid;
  logic          win_last;
  logic          busy;
  logic          overrun;

  hamming_window dut (
    .clk         (clk),
    .rst         (rst),
    .frame_in    (frame_in),
    .frame_ready (frame_ready),
    .win_sample  (win_sample),
    .win_index   (win_index),
    .win_valid   (win_valid),
    .win_last    (win_last),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected {valid, last, index, sample} per cycle, plus busy/overrun
  logic [21:0] exp_out  [0:MAXC-1];
  bit          exp_busy [0:MAXC-1];
  bit          exp_ovr  [0:MAXC-1];

  int ref_coef [0:FL-1];
  int obs      [0:FL-1];
  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int fill;
    int idx;
    int exp_t;
    int exp_r;
  } tv_t;
  tv_t tv [0:5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic int model_win(input int s, input int n);
    longint p;
    p = longint'(s) * longint'(ref_coef[n]);
`ifdef HAMMING_WINDOW_ROUND_EN
    return int'((p + 64'd16384) / 64'd32768);
`else
    return int'(p / 64'd32768);
`endif
  endfunction

  always @(negedge clk) begin
    logic [23:0] a;
    logic [23:0] e;
    if (chk_en && cyc < MAXC) begin
      e = {exp_out[cyc], exp_busy[cyc], exp_ovr[cyc]};
      a = {win_valid, win_last, win_index, win_sample, busy, overrun};
      if (!e[23]) a[21:2] = '0;
      chk($sformatf("cycle %0d outputs", cyc), 64'(a), 64'(e));
      if (win_valid === 1'b1) obs[win_index] = int'(win_sample);
    end
  end

  task automatic m_reset();
    for (int c = cyc + 1; c < MAXC; c++) begin
      exp_out[c]  = '0;
      exp_busy[c] = 1'b0;
      exp_ovr[c]  = 1'b0;
    end
  endtask

  // Model of one strobe in the current cycle: accepted only when the block is idle.
  task automatic m_strobe();
    int s;
    s = cyc;
    if (!rst) begin
      if (exp_busy[s]) begin
        for (int c = s + 1; c < MAXC; c++) exp_ovr[c] = 1'b1;
      end else begin
        for (int k = 0; k < FL; k++)
          if (s + k + 2 < MAXC)
            exp_out[s + k + 2] = {1'b1, (k == FL - 1), 8'(k), 12'(model_win(int'(frame_in[k]), k))};
        for (int c = s + 1; c <= s + FL - 1 && c < MAXC; c++) exp_busy[c] = 1'b1;
      end
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    rst         = 1'b0;
    frame_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) next();
  endtask

  task automatic strobe();
    frame_ready = 1'b1;
    m_strobe();
  endtask

  task automatic reset_now();
    rst = 1'b1;
    m_reset();
  endtask

  task automatic fill_const(input int v);
    for (int k = 0; k < FL; k++) frame_in[k] = SW'(v);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < FL; k++) frame_in[k] = SW'($urandom_range(0, 4095));
  endtask

  task automatic clear_obs();
    for (int k = 0; k < FL; k++) obs[k] = -1;
  endtask

  task automatic check_table(input int fillv);
    int expv;
    for (int i = 0; i < 6; i++) begin
      if (tv[i].fill == fillv) begin
`ifdef HAMMING_WINDOW_ROUND_EN
        expv = tv[i].exp_r;
`else
        expv = tv[i].exp_t;
`endif
        chk($sformatf("const %0d index %0d", fillv, tv[i].idx), 64'(obs[tv[i].idx]), 64'(expv));
      end
    end
  endtask

  initial begin
    real w;
    int  v;

    tv[0] = '{2048,   0,  163,  164};
    tv[1] = '{2048, 128, 2047, 2048};
    tv[2] = '{2048, 255,  163,  164};
    tv[3] = '{4095, 128, 4094, 4095};
    tv[4] = '{4095,   0,  327,  328};
    tv[5] = '{4095, 255,  327,  328};

    for (int n = 0; n < FL; n++) begin
      w = 32768.0 * (0.54 - 0.46 * $cos(2.0 * 3.14159265358979323846 * n / 255.0));
      v = $rtoi(w + 0.5);
      ref_coef[n] = (v > 32767) ? 32767 : v;
    end
    for (int c = 0; c < MAXC; c++) begin
      exp_out[c]  = '0;
      exp_busy[c] = 1'b0;
      exp_ovr[c]  = 1'b0;
    end
    fill_const(0);
    clear_obs();
    frame_ready = 1'b0;

    // reset held three cycles, then idle
    reset_now();
    next();
    chk_en = 1'b1;
    reset_now();
    next();
    reset_now();
    next();
    idle(10);
    chk("reset win_sample", 64'(win_sample), 64'd0);
    chk("reset win_index", 64'(win_index), 64'd0);
    chk("reset flags", 64'({win_valid, win_last, busy, overrun}), 64'd0);

    // constant 2048 frame
    fill_const(2048);
    clear_obs();
    strobe();
    idle(260);
    check_table(2048);

    // constant full-scale frame and symmetry
    fill_const(4095);
    clear_obs();
    strobe();
    idle(260);
    check_table(4095);
    for (int n = 0; n < 128; n += 9)
      chk($sformatf("symmetry %0d/%0d", n, 255 - n), 64'(obs[n]), 64'(obs[255 - n]));

    // back-to-back random frames
    fill_rand();
    strobe();
    idle(256);
    fill_rand();
    strobe();
    idle(260);

    // extra strobe mid-frame, then a normal frame at T+256
    fill_rand();
    strobe();
    idle(100);
    strobe();
    idle(156);
    chk("overrun sticky", 64'(overrun), 64'd1);
    fill_rand();
    strobe();
    idle(260);

    // reset mid-frame, then restart
    fill_rand();
    strobe();
    idle(50);
    reset_now();
    next();
    chk("after reset busy/valid/overrun", 64'({busy, win_valid, overrun}), 64'd0);
    idle(5);
    fill_rand();
    strobe();
    idle(260);

    // strobe coincident with reset is ignored
    fill_rand();
    reset_now();
    strobe();
    idle(6);
    chk("strobe under reset busy", 64'(busy), 64'd0);

    // random frames with small random gaps
    repeat (3) begin
      fill_rand();
      strobe();
      idle(256 + $urandom_range(0, 3));
    end
    idle(260);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
